// File: rtl/vga_frame_reader_pkg.sv
// Shared timing defaults, the pipeline control word and helpers for the
// VGA frame-buffer read side.
package vga_frame_reader_pkg;

    localparam int unsigned H_VIS_DEF  = 640;
    localparam int unsigned H_FP_DEF   = 16;
    localparam int unsigned H_SYNC_DEF = 96;
    localparam int unsigned H_BP_DEF   = 48;
    localparam int unsigned V_VIS_DEF  = 480;
    localparam int unsigned V_FP_DEF   = 10;
    localparam int unsigned V_SYNC_DEF = 2;
    localparam int unsigned V_BP_DEF   = 33;

    // Control bits that travel alongside the pixel through the read pipeline
    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
        logic fs;
    } vga_ctl_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_frame_reader_if.sv
// Frame-buffer read port: registered-read RAM, data valid one clock after address.
interface vga_frame_reader_if #(
    parameter int unsigned AW = 15,
    parameter int unsigned DW = 3
);
    logic [AW-1:0] addr_out;
    logic [DW-1:0] data_in;

    modport master (output addr_out, input data_in);
    modport slave  (input addr_out, output data_in);
endinterface

// File: rtl/vga_sync_counter.sv
// Raster counters: h_cnt/v_cnt with visible window, raw sync windows and
// end-of-line / end-of-frame strobes (sync flags are active-high here).
module vga_sync_counter
    import vga_frame_reader_pkg::*;
#(
    parameter int unsigned H_VIS  = H_VIS_DEF,
    parameter int unsigned H_FP   = H_FP_DEF,
    parameter int unsigned H_SYNC = H_SYNC_DEF,
    parameter int unsigned H_BP   = H_BP_DEF,
    parameter int unsigned V_VIS  = V_VIS_DEF,
    parameter int unsigned V_FP   = V_FP_DEF,
    parameter int unsigned V_SYNC = V_SYNC_DEF,
    parameter int unsigned V_BP   = V_BP_DEF,
    parameter int unsigned HW     = 10,
    parameter int unsigned VW     = 10
) (
    input  logic          clk,
    input  logic          reset,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          visible,
    output logic          hsync_act,
    output logic          vsync_act,
    output logic          line_end,
    output logic          frame_end
);
    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
    localparam logic [HW-1:0] H_SS_C   = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] H_SE_C   = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST_C = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
    localparam logic [VW-1:0] V_SS_C   = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] V_SE_C   = VW'(V_VIS + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST_C = VW'(V_TOT - 1);

    always_comb begin
        line_end  = (h_cnt == H_LAST_C);
        frame_end = line_end && (v_cnt == V_LAST_C);
        visible   = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
        hsync_act = (h_cnt >= H_SS_C) && (h_cnt < H_SE_C);
        vsync_act = (v_cnt >= V_SS_C) && (v_cnt < V_SE_C);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST_C) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_frame_reader.sv
// VGA read side: raster timing, multiplier-free upscaled buffer addressing and
// a 3-stage pipeline aligning RGB, syncs and frame_start at the pins.
module vga_frame_reader
    import vga_frame_reader_pkg::*;
#(
    parameter int unsigned AW          = 15,
    parameter int unsigned DW          = 3,
    parameter int unsigned FB_W        = 160,
    parameter int unsigned FB_H        = 120,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned H_VIS       = H_VIS_DEF,
    parameter int unsigned H_FP        = H_FP_DEF,
    parameter int unsigned H_SYNC      = H_SYNC_DEF,
    parameter int unsigned H_BP        = H_BP_DEF,
    parameter int unsigned V_VIS       = V_VIS_DEF,
    parameter int unsigned V_FP        = V_FP_DEF,
    parameter int unsigned V_SYNC      = V_SYNC_DEF,
    parameter int unsigned V_BP        = V_BP_DEF,
    parameter bit          SYNC_POL    = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    vga_frame_reader_if.master   fb,
    output logic                 vga_r,
    output logic                 vga_g,
    output logic                 vga_b,
    output logic                 vga_hsync,
    output logic                 vga_vsync,
    output logic                 frame_start
);
    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW    = cnt_width(H_TOT);
    localparam int unsigned VW    = cnt_width(V_TOT);

    localparam logic [VW-1:0] V_LAST_VIS = VW'(V_VIS - 1);
    localparam logic [AW-1:0] ROW_STEP   = AW'(FB_W);
    localparam logic          SYNC_ON    = SYNC_POL;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          visible, hsync_act, vsync_act, line_end, frame_end;
    logic [AW-1:0] row_base;
    logic [AW-1:0] col;
    vga_ctl_t      ctl0, st1, st2;

    vga_sync_counter #(
        .H_VIS (H_VIS),  .H_FP (H_FP),  .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_VIS (V_VIS),  .V_FP (V_FP),  .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HW    (HW),     .VW   (VW)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .visible   (visible),
        .hsync_act (hsync_act),
        .vsync_act (vsync_act),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    always_comb begin
        col      = AW'(h_cnt >> SCALE_SHIFT);
        ctl0.vis = visible;
        ctl0.hs  = hsync_act;
        ctl0.vs  = vsync_act;
        ctl0.fs  = (h_cnt == '0) && (v_cnt == '0);
    end

    // Advance one buffer row after every 2^SCALE_SHIFT display lines
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_base <= '0;
        end else if (line_end) begin
            if (frame_end)
                row_base <= '0;
            else if ((v_cnt < V_LAST_VIS) && (&v_cnt[SCALE_SHIFT-1:0]))
                row_base <= row_base + ROW_STEP;
        end
    end

    // Stage 1 issues the address, stage 2 waits on the RAM, stage 3 drives pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fb.addr_out <= '0;
            st1         <= '0;
            st2         <= '0;
            vga_r       <= 1'b0;
            vga_g       <= 1'b0;
            vga_b       <= 1'b0;
            vga_hsync   <= ~SYNC_ON;
            vga_vsync   <= ~SYNC_ON;
            frame_start <= 1'b0;
        end else begin
            fb.addr_out <= visible ? row_base + col : '0;
            st1         <= ctl0;
            st2         <= st1;
            vga_r       <= st2.vis & fb.data_in[2];
            vga_g       <= st2.vis & fb.data_in[1];
            vga_b       <= st2.vis & fb.data_in[0];
            vga_hsync   <= st2.hs ? SYNC_ON : ~SYNC_ON;
            vga_vsync   <= st2.vs ? SYNC_ON : ~SYNC_ON;
            frame_start <= st2.fs;
        end
    end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader on a shrunken raster: compares every output slot
// against a position-arithmetic model of the image, syncs and frame markers.
module tb_vga_frame_reader;
    import vga_frame_reader_pkg::*;

    localparam int unsigned AW = 6, DW = 3, FB_W = 8, FB_H = 6, SS = 1;
    localparam int unsigned H_VIS = 16, H_FP = 2, H_SYNC = 3, H_BP = 2;
    localparam int unsigned V_VIS = 12, V_FP = 1, V_SYNC = 2, V_BP = 2;
    localparam int unsigned HT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned VT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned FT = HT * VT;
    localparam int unsigned NPIX = FB_W * FB_H;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic vga_r, vga_g, vga_b, vga_hsync, vga_vsync, frame_start;
    logic [DW-1:0] ram [0:(1<<AW)-1];

    vga_frame_reader_if #(.AW(AW), .DW(DW)) bus ();

    vga_frame_reader #(
        .AW(AW), .DW(DW), .FB_W(FB_W), .FB_H(FB_H), .SCALE_SHIFT(SS),
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .fb(bus.master),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Registered-read buffer model
    always @(posedge clk) bus.data_in <= ram[bus.addr_out];

    int n_checks = 0;
    int n_pass = 0;
    int k;
    int last_fs;
    int hs_run, vs_run;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s k=%0d got=%0h expected=%0h", tag, k, got, exp);
    endtask

    // Expected pins after edge kk reflect raster position kk-3 since release
    task automatic check_slot(input int kk);
        logic [2:0] e_rgb;
        logic e_hs, e_vs, e_fs;
        logic [AW-1:0] e_addr;
        int t, x, y;
        e_rgb = 3'b000; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_addr = '0;
        if (kk >= 3) begin
            t = kk - 3; x = t % HT; y = (t / HT) % VT;
            if (x < H_VIS && y < V_VIS) e_rgb = ram[(y >> SS) * FB_W + (x >> SS)];
            e_hs = !(x >= H_VIS + H_FP && x < H_VIS + H_FP + H_SYNC);
            e_vs = !(y >= V_VIS + V_FP && y < V_VIS + V_FP + V_SYNC);
            e_fs = (x == 0 && y == 0);
        end
        if (kk >= 1) begin
            t = kk - 1; x = t % HT; y = (t / HT) % VT;
            if (x < H_VIS && y < V_VIS) e_addr = AW'((y >> SS) * FB_W + (x >> SS));
        end
        check_val("rgb", {29'd0, vga_r, vga_g, vga_b}, {29'd0, e_rgb});
        check_val("hsync", {31'd0, vga_hsync}, {31'd0, e_hs});
        check_val("vsync", {31'd0, vga_vsync}, {31'd0, e_vs});
        check_val("frame_start", {31'd0, frame_start}, {31'd0, e_fs});
        check_val("addr", {26'd0, bus.addr_out}, {26'd0, e_addr});
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            k++;
            check_slot(k);
            if (frame_start) begin
                if (last_fs >= 0) check_val("fs_period", 32'(k - last_fs), FT);
                last_fs = k;
            end
            if (!vga_hsync) hs_run++;
            else begin
                if (hs_run > 0) check_val("hsync_width", 32'(hs_run), H_SYNC);
                hs_run = 0;
            end
            if (!vga_vsync) vs_run++;
            else begin
                if (vs_run > 0) check_val("vsync_width", 32'(vs_run), V_SYNC * HT);
                vs_run = 0;
            end
        end
    endtask

    // Assert reset mid-cycle, check the asynchronous clear, load image, release
    task automatic reset_and_load(input int mode, input int hold);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("rst_rgb", {29'd0, vga_r, vga_g, vga_b}, 32'd0);
        check_val("rst_hsync", {31'd0, vga_hsync}, 32'd1);
        check_val("rst_vsync", {31'd0, vga_vsync}, 32'd1);
        check_val("rst_fs", {31'd0, frame_start}, 32'd0);
        check_val("rst_addr", {26'd0, bus.addr_out}, 32'd0);
        for (int a = 0; a < (1 << AW); a++) begin
            case (mode)
                0: ram[a] = DW'(a);
                1: ram[a] = (a == NPIX - 1) ? 3'b111 : 3'b000;
                2: ram[a] = 3'b111;
                3: ram[a] = DW'($urandom);
                default: ;
            endcase
        end
        repeat (hold) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        k = 0; last_fs = -1; hs_run = 0; vs_run = 0;
    endtask

    initial begin
        k = 0; last_fs = -1; hs_run = 0; vs_run = 0;
        for (int a = 0; a < (1 << AW); a++) ram[a] = '0;
        repeat (2) @(posedge clk);
        reset_and_load(0, 5);
        run_cycles(2 * FT + 10);
        reset_and_load(1, 2);
        run_cycles(FT + 5);
        reset_and_load(2, 2);
        run_cycles(FT + 5);
        for (int r = 0; r < 3; r++) begin
            reset_and_load(3, 2);
            run_cycles(int'($urandom_range(FT - 1, 3)));
            // Mid-frame reset keeps the same image content
            reset_and_load(4, 2);
            run_cycles(FT + 10);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #(2000000);
        $display("FAIL timeout k=%0d", k);
        $fatal(1, "timeout");
    end

endmodule
